// File: rtl/lsu_arbiter.sv
// Two-requester arbiter for the single LSU port: the core MEM stage (req0) and the loader/debug port (req1).
// Each transaction latches the command in IDLE, drives the LSU for one ACCESS cycle, then returns data in RESP.
module lsu_arbiter #(
    parameter int CORE_PRIO = 1,
    parameter int MAX_WAIT  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_addr,
    input  logic        i_req0_wren,
    input  logic [2:0]  i_req0_load_sel,
    input  logic [1:0]  i_req0_store_sel,
    input  logic [31:0] i_req0_st_data,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_addr,
    input  logic        i_req1_wren,
    input  logic [2:0]  i_req1_load_sel,
    input  logic [1:0]  i_req1_store_sel,
    input  logic [31:0] i_req1_st_data,
    output logic        o_req0_ready,
    output logic        o_req1_ready,
    output logic        o_rsp0_valid,
    output logic [31:0] o_rsp0_rdata,
    output logic        o_rsp1_valid,
    output logic [31:0] o_rsp1_rdata,
    output logic [31:0] o_lsu_addr,
    output logic        o_lsu_wren,
    output logic [2:0]  o_lsu_load_sel,
    output logic [1:0]  o_lsu_store_sel,
    output logic [31:0] o_lsu_st_data,
    input  logic [31:0] i_lsu_ld_data,
    output logic        o_busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [1:0]  state_r;
    logic [31:0] addr_r;
    logic        wren_r;
    logic [2:0]  load_sel_r;
    logic [1:0]  store_sel_r;
    logic [31:0] st_data_r;
    logic        owner_r;
    logic [31:0] rdata_r;
    logic [3:0]  wait_cnt_r;
    logic        last_grant_r;

    logic        win_valid_s;
    logic        win_sel_s;
    logic        accept_s;
    logic [31:0] sel_addr_s;
    logic        sel_wren_s;
    logic [2:0]  sel_load_sel_s;
    logic [1:0]  sel_store_sel_s;
    logic [31:0] sel_st_data_s;
    logic [3:0]  wait_cnt_nxt_s;
    logic        in_access_s;
    logic        in_resp_s;

    // Winner selection among the pending requesters; req1 is forced once req0 has used up its wait budget.
    always_comb begin
        win_valid_s = 1'b0;
        win_sel_s   = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            win_valid_s = 1'b1;
            if (CORE_PRIO != 0) begin
                win_sel_s = (wait_cnt_r == MAX_WAIT_C);
            end else begin
                win_sel_s = ~last_grant_r;
            end
        end else if (i_req0_valid) begin
            win_valid_s = 1'b1;
            win_sel_s   = 1'b0;
        end else if (i_req1_valid) begin
            win_valid_s = 1'b1;
            win_sel_s   = 1'b1;
        end else begin
            win_valid_s = 1'b0;
            win_sel_s   = 1'b0;
        end
    end

    assign accept_s     = (state_r == ST_IDLE) && win_valid_s && !i_rst;
    assign o_req0_ready = accept_s && !win_sel_s;
    assign o_req1_ready = accept_s && win_sel_s;

    // Command mux feeding the latch at the handshake edge.
    always_comb begin
        if (win_sel_s) begin
            sel_addr_s      = i_req1_addr;
            sel_wren_s      = i_req1_wren;
            sel_load_sel_s  = i_req1_load_sel;
            sel_store_sel_s = i_req1_store_sel;
            sel_st_data_s   = i_req1_st_data;
        end else begin
            sel_addr_s      = i_req0_addr;
            sel_wren_s      = i_req0_wren;
            sel_load_sel_s  = i_req0_load_sel;
            sel_store_sel_s = i_req0_store_sel;
            sel_st_data_s   = i_req0_st_data;
        end
    end

    // Starvation counter: counts core grants that bypassed a waiting req1, saturating at the budget.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (state_r == ST_IDLE) begin
            if (!i_req1_valid) begin
                wait_cnt_nxt_s = 4'd0;
            end else if (accept_s && win_sel_s) begin
                wait_cnt_nxt_s = 4'd0;
            end else if (accept_s && (wait_cnt_r != MAX_WAIT_C)) begin
                wait_cnt_nxt_s = wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r;
            end
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Transaction FSM, command latch, load-data capture and arbitration history.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            addr_r       <= 32'd0;
            wren_r       <= 1'b0;
            load_sel_r   <= 3'd0;
            store_sel_r  <= 2'd0;
            st_data_r    <= 32'd0;
            owner_r      <= 1'b0;
            rdata_r      <= 32'd0;
            wait_cnt_r   <= 4'd0;
            last_grant_r <= 1'b1;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_r       <= sel_addr_s;
                        wren_r       <= sel_wren_s;
                        load_sel_r   <= sel_load_sel_s;
                        store_sel_r  <= sel_store_sel_s;
                        st_data_r    <= sel_st_data_s;
                        owner_r      <= win_sel_s;
                        last_grant_r <= win_sel_s;
                        state_r      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rdata_r <= wren_r ? 32'd0 : i_lsu_ld_data;
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_access_s = (state_r == ST_ACCESS) && !i_rst;
    assign in_resp_s   = (state_r == ST_RESP) && !i_rst;

    // LSU strobes are only live during ACCESS; the unused select of each direction is forced idle.
    always_comb begin
        if (in_access_s) begin
            o_lsu_wren      = wren_r;
            o_lsu_load_sel  = wren_r ? 3'b000 : load_sel_r;
            o_lsu_store_sel = wren_r ? store_sel_r : 2'b00;
        end else begin
            o_lsu_wren      = 1'b0;
            o_lsu_load_sel  = 3'b000;
            o_lsu_store_sel = 2'b00;
        end
    end

    assign o_lsu_addr    = addr_r;
    assign o_lsu_st_data = st_data_r;

    assign o_rsp0_valid = in_resp_s && !owner_r;
    assign o_rsp1_valid = in_resp_s && owner_r;
    assign o_rsp0_rdata = o_rsp0_valid ? rdata_r : 32'd0;
    assign o_rsp1_rdata = o_rsp1_valid ? rdata_r : 32'd0;
    assign o_busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: vector table of single transactions plus arbitration,
// reset-abort and back-to-back sequences. A tiny memory/LED model stands in for the LSU.
module tb_lsu_arbiter;

    logic        clk;
    logic        i_rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr;
    logic        req0_wren, req1_wren;
    logic [2:0]  req0_load_sel, req1_load_sel;
    logic [1:0]  req0_store_sel, req1_store_sel;
    logic [31:0] req0_st_data, req1_st_data;
    logic [31:0] lsu_ld_data;

    logic        ready0, ready1, rsp0_valid, rsp1_valid, lsu_wren, busy;
    logic [31:0] rsp0_rdata, rsp1_rdata, lsu_addr, lsu_st_data;
    logic [2:0]  lsu_load_sel;
    logic [1:0]  lsu_store_sel;

    logic        b_ready0, b_ready1, b_rsp0_valid, b_rsp1_valid, b_lsu_wren, b_busy;
    logic [31:0] b_rsp0_rdata, b_rsp1_rdata, b_lsu_addr, b_lsu_st_data;
    logic [2:0]  b_lsu_load_sel;
    logic [1:0]  b_lsu_store_sel;

    logic [31:0] mem [16];
    logic [31:0] led;
    logic        mem_init;

    int n_pass;
    int n_total;

    lsu_arbiter #(.CORE_PRIO(1), .MAX_WAIT(4)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req0_valid(req0_valid), .i_req0_addr(req0_addr), .i_req0_wren(req0_wren),
        .i_req0_load_sel(req0_load_sel), .i_req0_store_sel(req0_store_sel), .i_req0_st_data(req0_st_data),
        .i_req1_valid(req1_valid), .i_req1_addr(req1_addr), .i_req1_wren(req1_wren),
        .i_req1_load_sel(req1_load_sel), .i_req1_store_sel(req1_store_sel), .i_req1_st_data(req1_st_data),
        .o_req0_ready(ready0), .o_req1_ready(ready1),
        .o_rsp0_valid(rsp0_valid), .o_rsp0_rdata(rsp0_rdata),
        .o_rsp1_valid(rsp1_valid), .o_rsp1_rdata(rsp1_rdata),
        .o_lsu_addr(lsu_addr), .o_lsu_wren(lsu_wren), .o_lsu_load_sel(lsu_load_sel),
        .o_lsu_store_sel(lsu_store_sel), .o_lsu_st_data(lsu_st_data),
        .i_lsu_ld_data(lsu_ld_data), .o_busy(busy)
    );

    lsu_arbiter #(.CORE_PRIO(0), .MAX_WAIT(4)) dut_rr (
        .i_clk(clk), .i_rst(i_rst),
        .i_req0_valid(req0_valid), .i_req0_addr(req0_addr), .i_req0_wren(req0_wren),
        .i_req0_load_sel(req0_load_sel), .i_req0_store_sel(req0_store_sel), .i_req0_st_data(req0_st_data),
        .i_req1_valid(req1_valid), .i_req1_addr(req1_addr), .i_req1_wren(req1_wren),
        .i_req1_load_sel(req1_load_sel), .i_req1_store_sel(req1_store_sel), .i_req1_st_data(req1_st_data),
        .o_req0_ready(b_ready0), .o_req1_ready(b_ready1),
        .o_rsp0_valid(b_rsp0_valid), .o_rsp0_rdata(b_rsp0_rdata),
        .o_rsp1_valid(b_rsp1_valid), .o_rsp1_rdata(b_rsp1_rdata),
        .o_lsu_addr(b_lsu_addr), .o_lsu_wren(b_lsu_wren), .o_lsu_load_sel(b_lsu_load_sel),
        .o_lsu_store_sel(b_lsu_store_sel), .o_lsu_st_data(b_lsu_st_data),
        .i_lsu_ld_data(lsu_ld_data), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LSU stand-in: word RAM at 0x2000 and an LED register at 0x7000.
    assign lsu_ld_data = (lsu_addr[31:12] == 20'h00002) ? mem[lsu_addr[5:2]] :
                         ((lsu_addr == 32'h0000_7000) ? led : 32'h0);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
            mem[0] <= 32'hDEAD_BEEF;
            mem[2] <= 32'h1122_3344;
            led    <= 32'h0;
        end else if (lsu_wren) begin
            if (lsu_addr == 32'h0000_7000) begin
                led <= lsu_st_data;
            end else if (lsu_addr[31:12] == 20'h00002) begin
                case (lsu_store_sel)
                    2'b11: mem[lsu_addr[5:2]] <= lsu_st_data;
                    2'b10: mem[lsu_addr[5:2]][16*lsu_addr[1] +: 16] <= lsu_st_data[15:0];
                    2'b01: mem[lsu_addr[5:2]][8*lsu_addr[1:0] +: 8] <= lsu_st_data[7:0];
                    default: ;
                endcase
            end
        end
    end

    typedef struct {
        logic        owner;
        logic [31:0] addr;
        logic        wren;
        logic [2:0]  ld_sel;
        logic [1:0]  st_sel;
        logic [31:0] st_data;
        logic [2:0]  exp_ld_sel;
        logic [1:0]  exp_st_sel;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req0_valid = 1'b0; req0_addr = 32'h0; req0_wren = 1'b0; req0_load_sel = 3'b0;
        req0_store_sel = 2'b0; req0_st_data = 32'h0;
        req1_valid = 1'b0; req1_addr = 32'h0; req1_wren = 1'b0; req1_load_sel = 3'b0;
        req1_store_sel = 2'b0; req1_st_data = 32'h0;
    endtask

    task automatic set_req(input logic owner, input logic [31:0] addr, input logic wren,
                           input logic [2:0] ld_sel, input logic [1:0] st_sel, input logic [31:0] data);
        if (owner) begin
            req1_valid = 1'b1; req1_addr = addr; req1_wren = wren;
            req1_load_sel = ld_sel; req1_store_sel = st_sel; req1_st_data = data;
        end else begin
            req0_valid = 1'b1; req0_addr = addr; req0_wren = wren;
            req0_load_sel = ld_sel; req0_store_sel = st_sel; req0_st_data = data;
        end
    endtask

    task automatic do_reset();
        clear_reqs();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        set_req(v.owner, v.addr, v.wren, v.ld_sel, v.st_sel, v.st_data);
        #1;
        check("idle_ready_own", {31'd0, v.owner ? ready1 : ready0}, 32'd1);
        check("idle_ready_other", {31'd0, v.owner ? ready0 : ready1}, 32'd0);
        step();
        clear_reqs();
        #1;
        check("acc_busy", {31'd0, busy}, 32'd1);
        check("acc_addr", lsu_addr, v.addr);
        check("acc_wren", {31'd0, lsu_wren}, {31'd0, v.wren});
        check("acc_load_sel", {29'd0, lsu_load_sel}, {29'd0, v.exp_ld_sel});
        check("acc_store_sel", {30'd0, lsu_store_sel}, {30'd0, v.exp_st_sel});
        check("acc_st_data", lsu_st_data, v.st_data);
        step();
        check("resp_valid_own", {31'd0, v.owner ? rsp1_valid : rsp0_valid}, 32'd1);
        check("resp_valid_other", {31'd0, v.owner ? rsp0_valid : rsp1_valid}, 32'd0);
        check("resp_rdata", v.owner ? rsp1_rdata : rsp0_rdata, v.exp_rdata);
        check("resp_wren_off", {31'd0, lsu_wren}, 32'd0);
        step();
        check("post_idle", {30'd0, busy, rsp0_valid | rsp1_valid}, 32'd0);
    endtask

    int gnt_a[$];
    int cyc_a[$];
    int gnt_b[$];
    int exp_a [10];
    int both_ready_err;

    initial begin
        n_pass = 0;
        n_total = 0;
        clear_reqs();
        mem_init = 1'b1;
        i_rst = 1'b1;
        step();
        mem_init = 1'b0;

        vecs[0] = '{1'b0, 32'h0000_2000, 1'b0, 3'b101, 2'b00, 32'h0,         3'b101, 2'b00, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_7000, 1'b1, 3'b101, 2'b11, 32'h0000_00A5, 3'b000, 2'b11, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_2004, 1'b1, 3'b001, 2'b11, 32'h1234_5678, 3'b000, 2'b11, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_2004, 1'b0, 3'b101, 2'b11, 32'h0,         3'b101, 2'b00, 32'h1234_5678};
        vecs[4] = '{1'b0, 32'h0000_2000, 1'b0, 3'b010, 2'b00, 32'h0,         3'b010, 2'b00, 32'hDEAD_BEEF};

        do_reset();
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {30'd0, ready0, ready1}, 32'd0);
        check("rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        check("rst_lsu_addr", lsu_addr, 32'd0);
        check("rst_lsu_ctl", {26'd0, lsu_wren, lsu_load_sel, lsu_store_sel}, 32'd0);
        check("rr_rst_outs", b_lsu_addr | b_lsu_st_data | b_rsp0_rdata | b_rsp1_rdata |
              {26'd0, b_busy, b_rsp0_valid, b_rsp1_valid, b_lsu_wren, b_ready0, b_ready1} |
              {27'd0, b_lsu_load_sel, b_lsu_store_sel}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            if (i == 1) check("led_after_sw", led, 32'h0000_00A5);
        end

        // Contention: both requesters valid continuously, grants recorded on both configurations.
        do_reset();
        set_req(1'b0, 32'h0000_2000, 1'b0, 3'b101, 2'b00, 32'h0);
        set_req(1'b1, 32'h0000_2004, 1'b0, 3'b101, 2'b00, 32'h0);
        #1;
        both_ready_err = 0;
        for (int c = 0; c < 30; c++) begin
            if (ready0 && ready1) both_ready_err++;
            if (ready0 || ready1) begin
                gnt_a.push_back(ready1 ? 1 : 0);
                cyc_a.push_back(c);
            end
            if (b_ready0 || b_ready1) gnt_b.push_back(b_ready1 ? 1 : 0);
            step();
        end
        clear_reqs();
        exp_a = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        check("prio_grant_count", gnt_a.size(), 32'd10);
        check("rr_grant_count", gnt_b.size(), 32'd10);
        check("one_ready_at_a_time", both_ready_err, 32'd0);
        for (int g = 0; g < 10; g++) begin
            check($sformatf("prio_grant_%0d", g), (g < gnt_a.size()) ? gnt_a[g] : -1, exp_a[g]);
            check($sformatf("prio_grant_cycle_%0d", g), (g < cyc_a.size()) ? cyc_a[g] : -1, 3 * g);
            check($sformatf("rr_grant_%0d", g), (g < gnt_b.size()) ? gnt_b[g] : -1, g % 2);
        end

        // Reset pulsed during the ACCESS cycle of a byte store: no write, no response.
        do_reset();
        set_req(1'b0, 32'h0000_2008, 1'b1, 3'b000, 2'b01, 32'h0000_00FF);
        #1;
        check("abort_ready0", {31'd0, ready0}, 32'd1);
        step();
        check("abort_acc_wren", {31'd0, lsu_wren}, 32'd1);
        i_rst = 1'b1;
        #1;
        check("abort_wren_gated", {31'd0, lsu_wren}, 32'd0);
        step();
        i_rst = 1'b0;
        clear_reqs();
        #1;
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("abort_addr_cleared", lsu_addr, 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("abort_no_rsp", {30'd0, rsp0_valid, lsu_wren}, 32'd0);
            step();
        end
        check("abort_mem_intact", mem[2], 32'h1122_3344);

        // req1 raised during req0 RESP waits for the next IDLE cycle.
        do_reset();
        set_req(1'b0, 32'h0000_2000, 1'b0, 3'b101, 2'b00, 32'h0);
        #1;
        check("b2b_ready0", {31'd0, ready0}, 32'd1);
        step();
        clear_reqs();
        step();
        set_req(1'b1, 32'h0000_2004, 1'b0, 3'b101, 2'b00, 32'h0);
        #1;
        check("b2b_resp0", rsp0_rdata, 32'hDEAD_BEEF);
        check("b2b_ready1_in_resp", {31'd0, ready1}, 32'd0);
        step();
        check("b2b_ready1_idle", {31'd0, ready1}, 32'd1);
        step();
        clear_reqs();
        #1;
        check("b2b_ready1_acc", {31'd0, ready1}, 32'd0);
        step();
        check("b2b_rsp1", {31'd0, rsp1_valid}, 32'd1);
        check("b2b_rsp1_rdata", rsp1_rdata, 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
